alu_req_arbiter: RTL

//  Shares the single 16-bit ALU between two requesters (REQ0, REQ1) with round-robin fairness.

---
 rtl/alu_req_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
//   Shares one multi-cycle ALU between two requesters with round-robin
//   fairness. One operation is in flight at a time: accept, issue, wait for
//   the fixed ALU latency, return the tagged result.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | arbitrate; combinational ready to the winner only
//   EXEC  | operands on the ALU bus, alu_en high for this one cycle
//   WAIT  | down-counter runs ALU_LAT cycles; result captured on count 0
//   RESP  | rsp_valid high, rsp_data/rsp_id held until rsp_ready
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req{0,1}_valid/_ready      operation handshake per requester
//   req{0,1}_a/_b/_fun         operands and function code per requester
//   alu_a/alu_b/alu_fun        registered operand bus to the ALU
//   alu_en                     one-cycle issue strobe
//   alu_out                    ALU result
//   rsp_valid/rsp_ready        response handshake
//   rsp_id/rsp_data            owning requester and captured result
//   busy                       high whenever the FSM is not in IDLE
module alu_req_arbiter #(
  parameter int DATA_W  = 16,
  parameter int FUN_W   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [FUN_W-1:0]  req0_fun,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [FUN_W-1:0]  req1_fun,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FUN_W-1:0]  alu_fun,
  output logic              alu_en,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

  localparam int              CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(ALU_LAT - 1);

  state_t              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [FUN_W-1:0]    alu_fun_q, alu_fun_d;
  logic                alu_en_q, alu_en_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                busy_q, busy_d;

  logic win;
  logic grant;

  // Pointer only matters on a tie; a lone requester always wins.
  // Ready is gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    win   = (req0_valid & req1_valid) ? ptr_q : req1_valid;
    grant = (state_q == IDLE) & (req0_valid | req1_valid) & rst_n;
  end

  assign req0_ready = grant & ~win;
  assign req1_ready = grant & win;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fun_d   = alu_fun_q;
    alu_en_d    = alu_en_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          alu_a_d   = win ? req1_a   : req0_a;
          alu_b_d   = win ? req1_b   : req0_b;
          alu_fun_d = win ? req1_fun : req0_fun;
          rsp_id_d  = win;
          ptr_d     = ~win;
          alu_en_d  = 1'b1;
          busy_d    = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        alu_en_d = 1'b0;
        cnt_d    = LAT_M1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d  = alu_out;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= '0;
      alu_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fun_q   <= alu_fun_d;
      alu_en_q    <= alu_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_fun   = alu_fun_q;
  assign alu_en    = alu_en_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule
